hazard_mc: RTL
==============

# hazard_mc

Parametrised multi-file hazard unit with a latency scoreboard, the successor to the single-cycle scalar/vector hazard unit of the 5-stage pipeline. It generates E-stage forwarding selects for NFILE register files from one generic per-operand path, and D-stage branch forwarding. It produces stall/flush for load-use, branch, busy and multi-cycle-producer hazards. A per-register countdown scoreboard tracks results of variable-latency units (vector MUL/MAC) that ordinary forwarding cannot cover.

## Interface
- NREG, 32, registers per file; AW = $clog2(NREG)
- NFILE, 2, number of register files (0 = scalar, 1 = vector); FW = max(1,$clog2(NFILE))
- LATW, 3, scoreboard counter width; max tracked latency 2^LATW-1
- MAXOUT, 4, max simultaneously pending destinations

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rsD, rtD  in  AW  D-stage source registers
- rs_fileD, rt_fileD  in  FW  file of each D source
- issueD  in  1  D instruction is a multi-cycle producer
- dstD  in  AW  its destination; dst_fileD  in  FW  its file
- latD  in  LATW  cycles its result stays unforwardable; 0 = untracked
- rsE, rtE  in  AW; rs_fileE, rt_fileE  in  FW  E-stage sources
- writeregE, writeregM, writeregW  in  AW  destinations in E/M/W
- fileE, fileM, fileW  in  FW  destination file in E/M/W
- regwriteE, regwriteM, regwriteW  in  1  write enable in E/M/W
- memtoregE, memtoregM  in  1  load in E/M
- branchD  in  2  nonzero = branch in D
- busy  in  1  memory/peripheral busy, freezes pipeline
- clear  in  1  synchronous scoreboard flush (exception/redirect)
- forwardaD, forwardbD  out  1  M→D forwarding for branch compare
- forwardaE, forwardbE  out  2  E operand select: 00 RF, 01 W, 10 M
- stallF, stallD, stallE, stallM, stallW, flushE  out  1  pipeline control
- pending  out  $clog2(MAXOUT+1)  number of nonzero scoreboard entries

## Operation
- Zero register: file 0 reg 0 only. Never forwarded, tracked or compared as a hazard. All regs of other files are real.
- match(X,f,r) = regwriteX & fileX==f & writeregX==r & !zero(f,r).
- forwardaE: 10 if match(M,rs_fileE,rsE), else 01 if match(W,…), else 00. M has priority. forwardbE uses the same rule on rt.
- forwardaD = rs_fileD==0 & match(M,0,rsD); forwardbD likewise on rt.
- lwstall = memtoregE & (match(E,rs_fileD,rsD) | match(E,rt_fileD,rtD)).
- brstall = |branchD & (match(E,·,rsD/rtD) | memtoregM & match(M,·,rsD/rtD)).
- Scoreboard: cnt[f][r], LATW bits each, all zero at reset.
- sbstall = cnt[rs_fileD][rsD]!=0 | cnt[rt_fileD][rtD]!=0 | issueD & (cnt[dst_fileD][dstD]!=0 | pending==MAXOUT). The dst term is a WAW hazard; the pending term is a structural-full hazard.
- stallD = lwstall | brstall | sbstall | busy; stallF = stallD.
- stallE = stallM = stallW = busy; flushE = stallD & ~busy.
- accept = issueD & ~stallD & latD!=0 & !zero(dst_fileD,dstD).

Per-entry next state, in priority order:
1. clear → 0
2. accept & entry addressed → latD
3. ~busy & cnt!=0 → cnt-1
4. otherwise hold

- pending = popcount(cnt!=0); it never exceeds MAXOUT.

## Timing
- Forwarding and stall outputs are combinational from inputs and registered cnt. Scoreboard updates are visible the cycle after the edge.
- Producer accepted at edge 0 with latD=L: cnt=L in cycle 1, reaching 1 in cycle L, with no busy. A dependent in D stalls in cycles 1..L and may leave D in cycle L+1.
- busy freezes all counters. Counter expiry is measured in advancing pipeline cycles.
- Since accept requires ~busy, load and decrement never conflict on one entry.
- clear beats accept in the same cycle. The caller asserts clear only when D is also flushed.
- Async reset: all cnt=0 and pending=0. Outputs then reduce to the pure combinational terms; with all inputs 0 every output is 0.
- Reset mid-operation discards all pending entries immediately, without waiting for a clock edge.

## Structure
- hazard_pkg: fwd_sel_e (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10), FILE_SCALAR=0, FILE_VECTOR=1, and the zero-register test function.
- Sub-module lat_scoreboard (NREG, NFILE, LATW, MAXOUT) holds the cnt array, load/decrement/clear logic, lookup ports and the pending popcount. hazard_mc holds forwarding and stall logic.

## Test plan
- Scalar ALU chain: E reads s3 (file 0) while M writes s3 and W writes s3 → forwardaE=10. With only W writing s3 → 01. With rsE=s0 → 00.
- File separation: M writes v3 (file 1), E reads s3 → forwardaE=00. E reads v0 while W writes v0 → forwardaE=01.
- Multi-cycle: accept v5 with latD=3, next instruction reads v5 → stallD=1 and flushE=1 for exactly 3 cycles, then 0. With busy high for 2 cycles in between → stall lasts 5 cycles, with flushE=0 during busy.
- WAW and full: MAXOUT=4 and four accepted entries → pending=4, issueD to a fifth register stalls. issueD to an already-pending v7 stalls until v7 expires.
- clear and reset: pending=3, then clear together with issueD → pending=0 next cycle and no load. Drop rst_n mid-countdown → cnt and pending are 0 asynchronously.
- Load-use and branch: lw s2 in E with D reading s2 → stallD=1, flushE=1. beq in D with M lw writing s4 = rsD → stallD=1. ALU in M writing s4 → forwardaD=1 and no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the multi-file hazard unit
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam int unsigned FILE_SCALAR = 0;
  localparam int unsigned FILE_VECTOR = 1;

  // Only scalar r0 is hardwired; every register of the other files is real.
  function automatic logic is_zero_reg(input logic [31:0] file_num, input logic [31:0] reg_num);
    return (file_num == 32'(FILE_SCALAR)) && (reg_num == 32'd0);
  endfunction

endpackage

// File: rtl/lat_scoreboard.sv
// rtl/lat_scoreboard.sv - per-register countdown of unforwardable multi-cycle results
module lat_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int NFILE  = 2,
  parameter int LATW   = 3,
  parameter int MAXOUT = 4,
  localparam int AW    = $clog2(NREG),
  localparam int FW    = (NFILE > 1) ? $clog2(NFILE) : 1,
  localparam int PW    = $clog2(MAXOUT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            busy_i,
  input  logic            load_i,
  input  logic [FW-1:0]   load_file_i,
  input  logic [AW-1:0]   load_reg_i,
  input  logic [LATW-1:0] load_lat_i,
  input  logic [FW-1:0]   rs_file_i,
  input  logic [AW-1:0]   rs_i,
  input  logic [FW-1:0]   rt_file_i,
  input  logic [AW-1:0]   rt_i,
  input  logic [FW-1:0]   dst_file_i,
  input  logic [AW-1:0]   dst_i,
  output logic            rs_busy_o,
  output logic            rt_busy_o,
  output logic            dst_busy_o,
  output logic [PW-1:0]   pending_o
);

  localparam int NE = NFILE * NREG;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;

  logic [LATW-1:0] cnt_q [NE];
  logic [LATW-1:0] cnt_d [NE];

  // Flat index of (file, reg); file-major layout.
  function automatic logic [IW-1:0] entry_idx(input logic [FW-1:0] f, input logic [AW-1:0] r);
    return IW'(int'(f) * NREG + int'(r));
  endfunction

  // Guards against file/reg codes beyond NFILE/NREG when those are not powers of two.
  function automatic logic entry_ok(input logic [FW-1:0] f, input logic [AW-1:0] r);
    return (int'(f) < NFILE) && (int'(r) < NREG);
  endfunction

  function automatic logic entry_busy(input logic [FW-1:0] f, input logic [AW-1:0] r);
    if (!entry_ok(f, r)) return 1'b0;
    return cnt_q[entry_idx(f, r)] != '0;
  endfunction

  assign rs_busy_o  = entry_busy(rs_file_i, rs_i);
  assign rt_busy_o  = entry_busy(rt_file_i, rt_i);
  assign dst_busy_o = entry_busy(dst_file_i, dst_i);

  // Next count per entry: clear, then load, then busy-gated countdown.
  always_comb begin
    for (int i = 0; i < NE; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_i) begin
        cnt_d[i] = '0;
      end else if (load_i && entry_ok(load_file_i, load_reg_i) &&
                   (IW'(i) == entry_idx(load_file_i, load_reg_i))) begin
        cnt_d[i] = load_lat_i;
      end else if (!busy_i && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - LATW'(1);
      end
    end
  end

  // Counter storage; reset drops every outstanding entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NE; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Number of live entries; accept is refused at MAXOUT so this cannot overflow.
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < NE; i++) begin
      if (cnt_q[i] != '0) pending_o = pending_o + PW'(1);
    end
  end

endmodule

// File: rtl/hazard_mc.sv
// rtl/hazard_mc.sv - multi-file forwarding and stall/flush control with latency scoreboard
module hazard_mc
  import hazard_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int NFILE  = 2,
  parameter int LATW   = 3,
  parameter int MAXOUT = 4,
  localparam int AW    = $clog2(NREG),
  localparam int FW    = (NFILE > 1) ? $clog2(NFILE) : 1,
  localparam int PW    = $clog2(MAXOUT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rsD,
  input  logic [AW-1:0]   rtD,
  input  logic [FW-1:0]   rs_fileD,
  input  logic [FW-1:0]   rt_fileD,
  input  logic            issueD,
  input  logic [AW-1:0]   dstD,
  input  logic [FW-1:0]   dst_fileD,
  input  logic [LATW-1:0] latD,
  input  logic [AW-1:0]   rsE,
  input  logic [AW-1:0]   rtE,
  input  logic [FW-1:0]   rs_fileE,
  input  logic [FW-1:0]   rt_fileE,
  input  logic [AW-1:0]   writeregE,
  input  logic [AW-1:0]   writeregM,
  input  logic [AW-1:0]   writeregW,
  input  logic [FW-1:0]   fileE,
  input  logic [FW-1:0]   fileM,
  input  logic [FW-1:0]   fileW,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic [1:0]      branchD,
  input  logic            busy,
  input  logic            clear,
  output logic            forwardaD,
  output logic            forwardbD,
  output logic [1:0]      forwardaE,
  output logic [1:0]      forwardbE,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            stallM,
  output logic            stallW,
  output logic            flushE,
  output logic [PW-1:0]   pending
);

  logic rs_busy, rt_busy, dst_busy;
  logic lwstall, brstall, sbstall, accept;

  // A stage produces (f, r) if it writes that exact file/register and it is not scalar r0.
  function automatic logic match(input logic we, input logic [FW-1:0] wf, input logic [AW-1:0] wr,
                                 input logic [FW-1:0] f, input logic [AW-1:0] r);
    return we && (wf == f) && (wr == r) && !is_zero_reg(32'(f), 32'(r));
  endfunction

  // One operand path shared by both E-stage sources; M is the younger result.
  function automatic fwd_sel_e e_sel(input logic [FW-1:0] f, input logic [AW-1:0] r);
    if (match(regwriteM, fileM, writeregM, f, r)) return FWD_M;
    if (match(regwriteW, fileW, writeregW, f, r)) return FWD_W;
    return FWD_RF;
  endfunction

  assign forwardaE = e_sel(rs_fileE, rsE);
  assign forwardbE = e_sel(rt_fileE, rtE);

  // Branch compare lives in D and only reads scalar registers.
  assign forwardaD = (rs_fileD == FW'(FILE_SCALAR)) && match(regwriteM, fileM, writeregM, rs_fileD, rsD);
  assign forwardbD = (rt_fileD == FW'(FILE_SCALAR)) && match(regwriteM, fileM, writeregM, rt_fileD, rtD);

  assign lwstall = memtoregE && (match(regwriteE, fileE, writeregE, rs_fileD, rsD) ||
                                 match(regwriteE, fileE, writeregE, rt_fileD, rtD));

  assign brstall = (|branchD) &&
                   (match(regwriteE, fileE, writeregE, rs_fileD, rsD) ||
                    match(regwriteE, fileE, writeregE, rt_fileD, rtD) ||
                    (memtoregM && (match(regwriteM, fileM, writeregM, rs_fileD, rsD) ||
                                   match(regwriteM, fileM, writeregM, rt_fileD, rtD))));

  // RAW on a tracked result, WAW on the destination, or no free tracking slot.
  assign sbstall = rs_busy || rt_busy || (issueD && (dst_busy || (pending == PW'(MAXOUT))));

  assign stallD = lwstall || brstall || sbstall || busy;
  assign stallF = stallD;
  assign stallE = busy;
  assign stallM = busy;
  assign stallW = busy;
  assign flushE = stallD && !busy;

  assign accept = issueD && !stallD && (latD != '0) && !is_zero_reg(32'(dst_fileD), 32'(dstD));

  lat_scoreboard #(
    .NREG   (NREG),
    .NFILE  (NFILE),
    .LATW   (LATW),
    .MAXOUT (MAXOUT)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear),
    .busy_i      (busy),
    .load_i      (accept),
    .load_file_i (dst_fileD),
    .load_reg_i  (dstD),
    .load_lat_i  (latD),
    .rs_file_i   (rs_fileD),
    .rs_i        (rsD),
    .rt_file_i   (rt_fileD),
    .rt_i        (rtD),
    .dst_file_i  (dst_fileD),
    .dst_i       (dstD),
    .rs_busy_o   (rs_busy),
    .rt_busy_o   (rt_busy),
    .dst_busy_o  (dst_busy),
    .pending_o   (pending)
  );

endmodule
